fp_adder_pipelined: RTL and testbench
=====================================

// Module: fp_adder_pipelined
// PURPOSE
//  Parametrised, signed IEEE-754-style floating-point adder: a + b -> sum, in a 3-stage pipeline with
//  valid/ready handshakes. Accepts full signed operands with unequal exponents, aligns them internally,
//  handles subtraction, normalises, rounds to nearest-even and resolves zero/inf/NaN.
//  Sits between operand-issue logic and the result writeback path in the FP datapath.
// PARAMETERS
//  EXP_W   8   exponent field width (bias = 2**(EXP_W-1)-1)
//  MAN_W   23  stored mantissa (fraction) width; hidden bit is implicit
//  (derived) W = 1+EXP_W+MAN_W  packed word width {sign, exp, frac}
// PORTS
//  clk        in   1  clock, all state on rising edge
//  rst        in   1  asynchronous, active-high reset
//  in_valid   in   1  operand pair present
//  in_ready   out  1  block accepts operand pair this cycle
//  in_a       in   W  operand A, packed {sign, exp, frac}
//  in_b       in   W  operand B, packed {sign, exp, frac}
//  out_valid  out  1  result present
//  out_ready  in   1  downstream accepts result this cycle
//  out_sum    out  W  rounded result, packed
//  out_flags  out  2  {overflow, invalid}, qualified by out_valid
// BEHAVIOUR
//  Handshake: transfer on valid&&ready at each side. Global stall: stall = out_valid && !out_ready;
//   in_ready = !stall. On stall all three stages hold; no beat lost, duplicated or reordered.
//   out_sum/out_flags stay stable while out_valid && !out_ready. Each stage carries a valid bit; bubbles collapse.
//  Latency: 3 cycles accept->out_valid without stall; throughput 1 result/cycle.
//  Reset (async, any time, incl. mid-operation): all stage valids 0, out_valid=0, out_sum=0, out_flags=0;
//   in-flight beats are discarded. in_ready=1 during and after reset.
//  S1 align: unpack; exp==0 -> operand is zero (subnormals flushed to zero, sign kept).
//   Swap so |A|>=|B| (compare {exp,frac}). Shift B mantissa (hidden bit incl.) right by
//   d = expA-expB into MAN_W+1 bits + guard, round, sticky; d >= MAN_W+3 -> B contributes sticky only.
//  S2 add: same signs -> add, else subtract (result >= 0 by swap). Width MAN_W+5 (carry+hidden+frac+G+R, S kept).
//   Result sign = sign of larger operand.
//  S3 normalise/round: carry -> shift right 1 (LSB ORed into sticky), exp+1. Else left-shift by leading-zero
//   count; if count >= exp, result flushes to zero. Round nearest-even on G/R/S; mantissa carry-out
//   from rounding -> exp+1. exp reaching 2**EXP_W-1 -> +/-inf, overflow=1.
//  Exact cancellation (x + -x) -> +0. (+0)+(-0) -> +0; (-0)+(-0) -> -0.
//  Specials (decided in S1, carried through): either NaN -> canonical qNaN {0, all-ones, 1 then zeros}.
//   inf + -inf -> canonical qNaN, invalid=1. inf + finite, inf + same-sign inf -> that inf, no flags.
//  Only overflow and invalid flags exist; inexact/underflow not reported.
// TESTING (EXP_W=8, MAN_W=23)
//  1) a=0x3F800000, b=0x3F800000, out_ready=1 -> out_sum=0x40000000 exactly 3 cycles after accept, flags=0.
//  2) a=0x3F800000, b=0xBF800000 -> 0x00000000; a=0x40400000(3.0), b=0xBF800000 -> 0x40000000.
//  3) RNE: a=0x3F800000, b=0x33800000 -> 0x3F800000 (tie to even);
//     a=0x3F800001, b=0x33800000 -> 0x3F800002.
//  4) a=b=0x7F7FFFFF -> 0x7F800000, flags=2'b10; a=0x7F800000, b=0xFF800000 -> 0x7FC00000, flags=2'b01;
//     a=0x7FC00001, b=0x3F800000 -> 0x7FC00000.
//  5) Back-pressure: stream 8 random pairs with in_valid=1, hold out_ready=0 for 6 cycles mid-stream ->
//     in_ready drops once 3 beats buffered, out_sum stable while stalled, all 8 results match model in order.
//  6) Assert rst for 1 cycle with 3 beats in flight -> out_valid=0 immediately (async), out_sum=0; next
//     accepted pair emerges 3 cycles after accept with correct value.

Source files
------------

// File: rtl/fp_adder_pipelined.sv
// Three-stage pipelined floating-point adder (a + b -> sum) with valid/ready handshakes.
// Stage 1 unpacks, resolves specials, orders the operands by magnitude and aligns the
// smaller one. Stage 2 adds or subtracts the mantissas. Stage 3 normalises, rounds to
// nearest-even and packs the result. A single global stall freezes every stage whenever
// the output holds a result that downstream has not taken.
module fp_adder_pipelined #(
   parameter  int EXP_W = 8,
   parameter  int MAN_W = 23,
   localparam int W     = 1 + EXP_W + MAN_W
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_a,
   input  logic [W-1:0] in_b,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_sum,
   output logic [1:0]   out_flags
);

   localparam int MW  = MAN_W + 1;        // mantissa including hidden bit
   localparam int XW  = MAN_W + 4;        // aligned mantissa: hidden + frac + G + R + S
   localparam int SW  = MAN_W + 5;        // sum: carry + aligned mantissa
   localparam int EW  = EXP_W + 2;        // exponent headroom for normalisation
   localparam int SHW = 2 * (MAN_W + 3);  // alignment shifter width

   localparam logic [W-1:0]  QNAN    = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
   localparam logic [EW-1:0] EXP_ALL = {2'b00, {EXP_W{1'b1}}};

   typedef struct packed {
      logic             valid;
      logic             sign;          // sign of the larger-magnitude operand
      logic             eff_sub;       // operand signs differ
      logic [EXP_W-1:0] exp;           // exponent of the larger operand
      logic [XW-1:0]    man_a;         // larger mantissa, G/R/S zero
      logic [XW-1:0]    man_b;         // smaller mantissa aligned to man_a
      logic             special;       // result fixed in stage 1
      logic [W-1:0]     special_word;
      logic             invalid;
   } s1_t;

   typedef struct packed {
      logic             valid;
      logic             sign;
      logic [EXP_W-1:0] exp;
      logic [SW-1:0]    sum;
      logic             special;
      logic [W-1:0]     special_word;
      logic             invalid;
   } s2_t;

   typedef struct packed {
      logic         valid;
      logic [W-1:0] sum;
      logic [1:0]   flags;             // {overflow, invalid}
   } s3_t;

   s1_t  s1_d, s1_q;
   s2_t  s2_d, s2_q;
   s3_t  s3_d, s3_q;
   logic stall;

   // Leading-zero count of the pre-normalisation mantissa.
   function automatic logic [EW-1:0] count_lz(input logic [XW-1:0] v);
      logic found;
      count_lz = '0;
      found    = 1'b0;
      for (int i = XW - 1; i >= 0; i--) begin
         if (!found) begin
            if (v[i]) found = 1'b1;
            else      count_lz = count_lz + EW'(1);
         end
      end
   endfunction

   assign stall     = s3_q.valid && !out_ready;
   assign in_ready  = !stall;
   assign out_valid = s3_q.valid;
   assign out_sum   = s3_q.sum;
   assign out_flags = s3_q.flags;

   // Stage 1: unpack, resolve specials, order by magnitude, align the smaller mantissa.
   always_comb begin
      logic             sa, sb, za, zb, nan_a, nan_b, inf_a, inf_b, swap, far;
      logic [EXP_W-1:0] ea, eb, big_e, sml_e, d;
      logic [W-2:0]     mag_a, mag_b, big_mag, sml_mag;
      logic [MW-1:0]    man_big, man_sml;
      logic [SHW-1:0]   shifted;
      logic [XW-1:0]    aligned;

      sa    = in_a[W-1];
      sb    = in_b[W-1];
      ea    = in_a[W-2 -: EXP_W];
      eb    = in_b[W-2 -: EXP_W];
      za    = (ea == '0);
      zb    = (eb == '0);
      inf_a = (ea == '1) && (in_a[MAN_W-1:0] == '0);
      inf_b = (eb == '1) && (in_b[MAN_W-1:0] == '0);
      nan_a = (ea == '1) && (in_a[MAN_W-1:0] != '0);
      nan_b = (eb == '1) && (in_b[MAN_W-1:0] != '0);

      // Subnormals are flushed: a zero exponent means a zero magnitude.
      mag_a   = za ? '0 : in_a[W-2:0];
      mag_b   = zb ? '0 : in_b[W-2:0];
      swap    = (mag_b > mag_a);
      big_mag = swap ? mag_b : mag_a;
      sml_mag = swap ? mag_a : mag_b;
      big_e   = big_mag[W-2:MAN_W];
      sml_e   = sml_mag[W-2:MAN_W];
      man_big = {big_e != '0, big_mag[MAN_W-1:0]};
      man_sml = {sml_e != '0, sml_mag[MAN_W-1:0]};
      d       = big_e - sml_e;
      far     = ({1'b0, d} >= (EXP_W+1)'(MAN_W + 3));

      // Shift into hidden+frac+G+R; everything falling below R folds into sticky.
      shifted = {man_sml, {(MAN_W+5){1'b0}}} >> d;
      aligned = far ? {{(XW-1){1'b0}}, |man_sml}
                    : {shifted[SHW-1 -: MAN_W+3], |shifted[MAN_W+2:0]};

      // NOTE: the whole struct is defaulted first so no path leaves a field unassigned (no latch).
      s1_d         = '0;
      s1_d.valid   = in_valid;
      s1_d.sign    = swap ? sb : sa;
      s1_d.eff_sub = sa ^ sb;
      s1_d.exp     = big_e;
      s1_d.man_a   = {man_big, 3'b000};
      s1_d.man_b   = aligned;

      if (nan_a || nan_b) begin
         s1_d.special      = 1'b1;
         s1_d.special_word = QNAN;
      end else if (inf_a && inf_b && (sa != sb)) begin
         s1_d.special      = 1'b1;
         s1_d.special_word = QNAN;
         s1_d.invalid      = 1'b1;
      end else if (inf_a) begin
         s1_d.special      = 1'b1;
         s1_d.special_word = in_a;
      end else if (inf_b) begin
         s1_d.special      = 1'b1;
         s1_d.special_word = in_b;
      end else if (za && zb) begin
         // (+0)+(-0) is +0; only two negative zeros give -0.
         s1_d.special      = 1'b1;
         s1_d.special_word = {sa & sb, {(W-1){1'b0}}};
      end
   end

   // Stage 2: magnitude add or subtract; the swap guarantees a non-negative difference.
   always_comb begin
      s2_d              = '0;
      s2_d.valid        = s1_q.valid;
      s2_d.sign         = s1_q.sign;
      s2_d.exp          = s1_q.exp;
      s2_d.special      = s1_q.special;
      s2_d.special_word = s1_q.special_word;
      s2_d.invalid      = s1_q.invalid;
      s2_d.sum          = s1_q.eff_sub ? ({1'b0, s1_q.man_a} - {1'b0, s1_q.man_b})
                                       : ({1'b0, s1_q.man_a} + {1'b0, s1_q.man_b});
   end

   // Stage 3: normalise, round to nearest-even, detect overflow and pack.
   always_comb begin
      logic          carry, rup;
      logic [XW-1:0] n_raw, n;
      logic [EW-1:0] lz, exp_n, exp_r;
      logic [MW:0]   mant;
      logic [MAN_W-1:0] frac;

      carry = s2_q.sum[SW-1];
      n_raw = s2_q.sum[XW-1:0];
      lz    = count_lz(n_raw);

      if (carry) begin
         n     = {s2_q.sum[SW-1:2], |s2_q.sum[1:0]};
         exp_n = {2'b00, s2_q.exp} + EW'(1);
      end else begin
         n     = n_raw << lz;
         exp_n = {2'b00, s2_q.exp} - lz;
      end

      // Round up when G is set and (R or S or the kept LSB) breaks the tie.
      rup   = n[2] & (n[1] | n[0] | n[3]);
      mant  = {1'b0, n[XW-1:3]} + {{MW{1'b0}}, rup};
      frac  = mant[MW] ? mant[MAN_W:1] : mant[MAN_W-1:0];
      exp_r = exp_n + {{(EW-1){1'b0}}, mant[MW]};

      s3_d       = '0;
      s3_d.valid = s2_q.valid;
      if (s2_q.special) begin
         s3_d.sum   = s2_q.special_word;
         s3_d.flags = {1'b0, s2_q.invalid};
      end else if (s2_q.sum == '0) begin
         s3_d.sum = '0;                                   // exact cancellation gives +0
      end else if (!carry && (lz >= {2'b00, s2_q.exp})) begin
         s3_d.sum = {s2_q.sign, {(W-1){1'b0}}};           // would be subnormal: flush
      end else if (exp_r >= EXP_ALL) begin
         s3_d.sum   = {s2_q.sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
         s3_d.flags = 2'b10;
      end else begin
         s3_d.sum = {s2_q.sign, exp_r[EXP_W-1:0], frac};
      end
   end

   // Pipeline registers: all stages advance together unless the output is stalled.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_q <= '0;
         s2_q <= '0;
         s3_q <= '0;
      end else if (!stall) begin
         // NOTE: non-blocking assignments let each stage capture the previous stage's old value.
         s1_q <= s1_d;
         s2_q <= s2_d;
         s3_q <= s3_d;
      end
   end

endmodule

// File: tb/tb_fp_adder_pipelined.sv
// Directed self-checking bench for fp_adder_pipelined (single precision).
// Inputs are driven just after the falling edge; outputs are sampled 1 time unit later,
// well away from the rising edge that moves the pipeline.
module tb_fp_adder_pipelined;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_a = '0;
   logic [31:0] in_b = '0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [31:0] out_sum;
   logic [1:0]  out_flags;

   int n_checks = 0;
   int n_fails  = 0;

   // Back-pressure stream: operands and hand-computed sums.
   logic [31:0] bp_a [8] = '{32'h3F800000, 32'h40000000, 32'h3FC00000, 32'hC0000000,
                             32'h00000000, 32'h40800000, 32'h41200000, 32'hBF800000};
   logic [31:0] bp_b [8] = '{32'h3F800000, 32'h3F800000, 32'h3F000000, 32'h3F000000,
                             32'hC0400000, 32'hC0800000, 32'h3E800000, 32'hBF800000};
   logic [31:0] bp_s [8] = '{32'h40000000, 32'h40400000, 32'h40000000, 32'hBFC00000,
                             32'hC0400000, 32'h00000000, 32'h41240000, 32'hC0000000};

   fp_adder_pipelined #(.EXP_W(8), .MAN_W(23)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sum   (out_sum),
      .out_flags (out_flags)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fails++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Issue one pair on an idle pipeline (called just after a falling edge) and check the
   // result, its flags and that it appears on the third rising edge counting the accept edge.
   task automatic run_single(input string tag, input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] exp_sum, input logic [1:0] exp_flags);
      int lat;
      in_a     = a;
      in_b     = b;
      in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      lat      = 1;
      #1;
      while (!out_valid && lat < 10) begin
         @(posedge clk);
         @(negedge clk);
         #1;
         lat++;
      end
      check({tag, "_latency"}, 32'(lat), 32'd3);
      check({tag, "_sum"}, out_sum, exp_sum);
      check({tag, "_flags"}, 32'(out_flags), 32'(exp_flags));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int          sent, got, cyc, stall_cycles;
      logic [31:0] held;
      logic        held_ok;

      // Reset state.
      #2 rst = 1'b1;
      #1;
      check("reset_out_valid", 32'(out_valid), 32'd0);
      check("reset_out_sum", out_sum, 32'h0);
      check("reset_out_flags", 32'(out_flags), 32'd0);
      check("reset_in_ready", 32'(in_ready), 32'd1);
      @(negedge clk);
      rst = 1'b0;
      #1;

      // Basic add, cancellation, subtraction.
      run_single("one_plus_one", 32'h3F800000, 32'h3F800000, 32'h40000000, 2'b00);
      run_single("cancel",       32'h3F800000, 32'hBF800000, 32'h00000000, 2'b00);
      run_single("three_m_one",  32'h40400000, 32'hBF800000, 32'h40000000, 2'b00);
      // Round to nearest-even: exact tie stays even, tie on odd LSB rounds up.
      run_single("rne_tie_even", 32'h3F800000, 32'h33800000, 32'h3F800000, 2'b00);
      run_single("rne_tie_odd",  32'h3F800001, 32'h33800000, 32'h3F800002, 2'b00);
      // Overflow and specials.
      run_single("overflow",     32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000, 2'b10);
      run_single("inf_m_inf",    32'h7F800000, 32'hFF800000, 32'h7FC00000, 2'b01);
      run_single("nan_in",       32'h7FC00001, 32'h3F800000, 32'h7FC00000, 2'b00);
      run_single("inf_p_fin",    32'h7F800000, 32'h3F800000, 32'h7F800000, 2'b00);
      run_single("ninf_p_ninf",  32'hFF800000, 32'hFF800000, 32'hFF800000, 2'b00);
      // Signed zeros.
      run_single("pz_p_nz",      32'h00000000, 32'h80000000, 32'h00000000, 2'b00);
      run_single("nz_p_nz",      32'h80000000, 32'h80000000, 32'h80000000, 2'b00);

      // Let the last result drain before streaming.
      @(posedge clk);
      @(negedge clk);

      // Back-pressure: continuous stream, out_ready low for cycles 4..9.
      sent         = 0;
      got          = 0;
      cyc          = 0;
      stall_cycles = 0;
      held         = '0;
      held_ok      = 1'b0;
      while (got < 8 && cyc < 80) begin
         out_ready = !(cyc >= 4 && cyc < 10);
         in_valid  = (sent < 8);
         if (sent < 8) begin
            in_a = bp_a[sent];
            in_b = bp_b[sent];
         end
         #1;
         if (out_valid && !out_ready) begin
            stall_cycles++;
            check("bp_in_ready_low", 32'(in_ready), 32'd0);
            if (stall_cycles == 1) check("bp_buffered", 32'(sent - got), 32'd3);
            if (held_ok) check("bp_sum_stable", out_sum, held);
            held    = out_sum;
            held_ok = 1'b1;
         end else begin
            held_ok = 1'b0;
         end
         if (out_valid && out_ready) begin
            check($sformatf("bp_result%0d", got), out_sum, bp_s[got]);
            check($sformatf("bp_flags%0d", got), 32'(out_flags), 32'd0);
            got++;
         end
         if (in_valid && in_ready) sent++;
         @(posedge clk);
         @(negedge clk);
         cyc++;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      check("bp_result_count", 32'(got), 32'd8);
      check("bp_stall_cycles", 32'(stall_cycles), 32'd6);
      #1;

      // Asynchronous reset with three beats in flight.
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1;
         in_a     = bp_a[i];
         in_b     = bp_b[i];
         @(posedge clk);
         @(negedge clk);
      end
      in_valid = 1'b0;
      #1;
      check("rst_pre_valid", 32'(out_valid), 32'd1);
      rst = 1'b1;
      #1;
      check("rst_async_valid", 32'(out_valid), 32'd0);
      check("rst_async_sum", out_sum, 32'h0);
      check("rst_async_flags", 32'(out_flags), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd1);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         check("rst_no_ghost", 32'(out_valid), 32'd0);
         @(posedge clk);
         @(negedge clk);
      end
      #1;
      run_single("post_reset", 32'h41200000, 32'h3E800000, 32'h41240000, 2'b00);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
